gpio_reg_bus_initiator: RTL

//  Bus initiator that drives the GPIO/ADC/capsense register-slave strobe interface
//  (chip_sel, read_reg, write_reg, busaddress, busdata_in; return busdata_to_cpu).

---
 rtl/gpio_reg_bus_initiator.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/gpio_reg_bus_initiator.sv
// Replays queued read/write commands as timed chip_sel/read_reg/write_reg strobe sequences
// towards the GPIO/ADC/capsense register slave, returning one response per command.
module gpio_reg_bus_initiator #(
  parameter int AddrWidth    = 16,
  parameter int BusWidth     = 32,
  parameter int StrobeCycles = 3,
  parameter int ReadLatency  = 4,
  parameter int GapCycles    = 2,
  parameter int CmdFifoDepth = 4
) (
  input  logic                 reg_clk,
  input  logic                 reset_reg_N,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [AddrWidth-1:0] cmd_addr,
  input  logic [BusWidth-1:0]  cmd_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_write,
  output logic [BusWidth-1:0]  rsp_rdata,
  output logic                 busy,
  output logic                 chip_sel,
  output logic                 read_reg,
  output logic                 write_reg,
  output logic [AddrWidth-3:0] busaddress,
  output logic [BusWidth-1:0]  busdata_in,
  input  logic [BusWidth-1:0]  busdata_to_cpu
);

  localparam int PtrW = $clog2(CmdFifoDepth);

  typedef struct packed {
    logic                 wr;
    logic [AddrWidth-3:0] addr;
    logic [BusWidth-1:0]  dat;
  } cmd_t;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_STROBE, S_WAIT, S_CAPTURE, S_RESP, S_GAP
  } state_t;

  cmd_t            r_mem [CmdFifoDepth];
  logic [PtrW-1:0] r_wr_ptr, r_rd_ptr;
  logic [PtrW:0]   r_count;
  logic            w_full, w_empty, w_push, w_pop;
  cmd_t            w_head;

  state_t               r_state, w_state_nxt;
  logic [15:0]          r_cnt, w_cnt_nxt;
  logic                 r_wr, w_wr_nxt;
  logic                 r_chip_sel, w_cs_nxt;
  logic                 r_read_reg, w_rd_nxt;
  logic                 r_write_reg, w_wrs_nxt;
  logic [AddrWidth-3:0] r_busaddress, w_addr_nxt;
  logic [BusWidth-1:0]  r_busdata_in, w_data_nxt;
  logic                 r_rsp_valid, w_rv_nxt;
  logic                 r_rsp_write, w_rw_nxt;
  logic [BusWidth-1:0]  r_rsp_rdata, w_rdat_nxt;

  assign w_full  = (r_count == (PtrW+1)'(CmdFifoDepth));
  assign w_empty = (r_count == '0);
  assign w_push  = cmd_valid && !w_full;
  assign w_head  = r_mem[r_rd_ptr];

  always_ff @(posedge reg_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= '{wr: cmd_write, addr: cmd_addr[AddrWidth-1:2], dat: cmd_wdata};
  end

  always_ff @(posedge reg_clk or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
      r_count <= r_count + (PtrW+1)'(w_push) - (PtrW+1)'(w_pop);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pop       = 1'b0;
    w_wr_nxt    = r_wr;
    w_cs_nxt    = r_chip_sel;
    w_rd_nxt    = r_read_reg;
    w_wrs_nxt   = r_write_reg;
    w_addr_nxt  = r_busaddress;
    w_data_nxt  = r_busdata_in;
    w_rv_nxt    = r_rsp_valid;
    w_rw_nxt    = r_rsp_write;
    w_rdat_nxt  = r_rsp_rdata;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_wr_nxt    = w_head.wr;
          w_addr_nxt  = w_head.addr;
          w_data_nxt  = w_head.dat;
          w_cs_nxt    = 1'b1;
          w_state_nxt = S_SETUP;
        end
      end
      S_SETUP: begin
        w_cnt_nxt   = '0;
        w_rd_nxt    = !r_wr;
        w_wrs_nxt   = r_wr;
        w_state_nxt = S_STROBE;
      end
      S_STROBE: begin
        if (r_cnt == 16'(StrobeCycles - 1)) begin
          w_rd_nxt  = 1'b0;
          w_wrs_nxt = 1'b0;
          w_cnt_nxt = '0;
          if (r_wr) begin
            w_cs_nxt    = 1'b0;
            w_rv_nxt    = 1'b1;
            w_rw_nxt    = 1'b1;
            w_rdat_nxt  = '0;
            w_state_nxt = S_RESP;
          end else begin
            w_state_nxt = S_WAIT;
          end
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      S_WAIT: begin
        if (r_cnt == 16'(ReadLatency - 1)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_CAPTURE;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      S_CAPTURE: begin
        w_cs_nxt    = 1'b0;
        w_rv_nxt    = 1'b1;
        w_rw_nxt    = 1'b0;
        w_rdat_nxt  = busdata_to_cpu;
        w_state_nxt = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_rv_nxt    = 1'b0;
          w_cnt_nxt   = '0;
          // The IDLE cycle before the pop is the last of the GapCycles quiet cycles.
          w_state_nxt = (GapCycles > 1) ? S_GAP : S_IDLE;
        end
      end
      S_GAP: begin
        if (r_cnt == 16'(GapCycles - 2)) w_state_nxt = S_IDLE;
        else                             w_cnt_nxt   = r_cnt + 16'd1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge reg_clk or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_wr         <= 1'b0;
      r_chip_sel   <= 1'b0;
      r_read_reg   <= 1'b0;
      r_write_reg  <= 1'b0;
      r_busaddress <= '0;
      r_busdata_in <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_write  <= 1'b0;
      r_rsp_rdata  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_wr         <= w_wr_nxt;
      r_chip_sel   <= w_cs_nxt;
      r_read_reg   <= w_rd_nxt;
      r_write_reg  <= w_wrs_nxt;
      r_busaddress <= w_addr_nxt;
      r_busdata_in <= w_data_nxt;
      r_rsp_valid  <= w_rv_nxt;
      r_rsp_write  <= w_rw_nxt;
      r_rsp_rdata  <= w_rdat_nxt;
    end
  end

  assign cmd_ready  = !w_full;
  assign busy       = (r_state != S_IDLE) || !w_empty;
  assign chip_sel   = r_chip_sel;
  assign read_reg   = r_read_reg;
  assign write_reg  = r_write_reg;
  assign busaddress = r_busaddress;
  assign busdata_in = r_busdata_in;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_write  = r_rsp_write;
  assign rsp_rdata  = r_rsp_rdata;

endmodule
